// File: rtl/adc_read_control_pkg.sv
// Shared types and constants for the laser-power-monitor ADC serial reader.
package adc_read_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      SHIFT,
      CSUP,
      GAP,
      DONE
   } adcState_t;

   localparam int unsigned SCLK_DIV       = 8;
   localparam int unsigned SAMPLE_PHASE   = 4;
   localparam int unsigned CS_PHASE       = 1;

   localparam int unsigned FRAME_BITS_DEF = 16;
   localparam int unsigned DATA_BITS_DEF  = 12;
   localparam int unsigned LEAD_BITS_DEF  = 4;
   localparam int unsigned GAP_SCLKS_DEF  = 11;

endpackage

// File: rtl/adc_read_control_sclk_gen.sv
// Free-running SCLK divider for the ADC reader: phase counter, registered
// SCLK_AD and single-cycle strobes for the chip-select and sample phases.
module adc_sclk_gen
   import adc_read_pkg::*;
(
   input  logic clk,
   input  logic Reset,
   output logic SCLK_AD,
   output logic csStrobe,
   output logic sampleStrobe
);

   localparam int unsigned PHASE_W = $clog2(SCLK_DIV);

   logic [PHASE_W-1:0] phase;

   always_ff @(posedge clk) begin
      if (Reset) begin
         phase   <= '0;
         SCLK_AD <= 1'b0;
      end else begin
         phase   <= phase + PHASE_W'(1);
         SCLK_AD <= (phase < PHASE_W'(SCLK_DIV / 2));
      end
   end

   assign csStrobe     = (phase == PHASE_W'(CS_PHASE));
   assign sampleStrobe = (phase == PHASE_W'(SAMPLE_PHASE));

endmodule

// File: rtl/adc_read_control.sv
// SPI-style reader for the 12-bit laser-power ADC: frames CS_AD, shifts
// DOUT_AD in MSB-first and publishes the result. Option: ADC_LEAD_CHECK_EN.
module adc_read_control
   import adc_read_pkg::*;
#(
   parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
   parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
   parameter int unsigned LEAD_BITS  = LEAD_BITS_DEF,
   parameter int unsigned GAP_SCLKS  = GAP_SCLKS_DEF
)
(
   input  logic                 clk,
   input  logic                 Reset,
   input  logic                 ADStartFlag,
   input  logic                 DOUT_AD,
   output logic                 SCLK_AD,
   output logic                 CS_AD,
   output logic [DATA_BITS-1:0] ADData,
   output logic                 ADRdFinishFlag,
   output logic                 ADBusy,
   output logic                 ADErrFlag
);

   localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);
   localparam int unsigned GAP_W = $clog2(GAP_SCLKS + 1);
`ifdef ADC_LEAD_CHECK_EN
   localparam int unsigned SH_BITS = LEAD_BITS + DATA_BITS;
`else
   localparam int unsigned SH_BITS = DATA_BITS;
`endif

   adcState_t          state;
   logic [CNT_W-1:0]   bitCnt;
   logic [GAP_W-1:0]   gapCnt;
   logic [SH_BITS-1:0] shreg;
   logic               csStrobe;
   logic               sampleStrobe;
   logic               shiftEn;

   adc_sclk_gen sclkGen (
      .clk          (clk),
      .Reset        (Reset),
      .SCLK_AD      (SCLK_AD),
      .csStrobe     (csStrobe),
      .sampleStrobe (sampleStrobe)
   );

   // Without the lead check the leading bits are simply never shifted in.
   always_comb begin
`ifdef ADC_LEAD_CHECK_EN
      shiftEn = 1'b1;
`else
      shiftEn = (bitCnt >= CNT_W'(LEAD_BITS));
`endif
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state          <= IDLE;
         CS_AD          <= 1'b1;
         ADBusy         <= 1'b0;
         ADRdFinishFlag <= 1'b0;
         ADData         <= '0;
         bitCnt         <= '0;
         gapCnt         <= '0;
         shreg          <= '0;
`ifdef ADC_LEAD_CHECK_EN
         ADErrFlag      <= 1'b0;
`endif
      end else begin
         ADRdFinishFlag <= 1'b0;
`ifdef ADC_LEAD_CHECK_EN
         ADErrFlag      <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (ADStartFlag) begin
                  ADBusy <= 1'b1;
                  state  <= ALIGN;
               end
            end
            ALIGN: begin
               if (csStrobe) begin
                  CS_AD  <= 1'b0;
                  bitCnt <= '0;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               if (sampleStrobe) begin
                  if (shiftEn) begin
                     shreg <= {shreg[SH_BITS-2:0], DOUT_AD};
                  end
                  bitCnt <= bitCnt + CNT_W'(1);
                  if (bitCnt == CNT_W'(FRAME_BITS - 1)) begin
                     state <= CSUP;
                  end
               end
            end
            CSUP: begin
               if (csStrobe) begin
                  CS_AD  <= 1'b1;
                  gapCnt <= '0;
                  state  <= GAP;
               end
            end
            GAP: begin
               // Result and finish pulse are registered on the way into DONE
               // so they are visible during the DONE cycle itself.
               if (sampleStrobe) begin
                  gapCnt <= gapCnt + GAP_W'(1);
                  if (gapCnt == GAP_W'(GAP_SCLKS - 1)) begin
                     state          <= DONE;
                     ADRdFinishFlag <= 1'b1;
                     ADBusy         <= 1'b0;
`ifdef ADC_LEAD_CHECK_EN
                     if (shreg[SH_BITS-1 -: LEAD_BITS] != '0) begin
                        ADErrFlag <= 1'b1;
                     end else begin
                        ADData <= shreg[DATA_BITS-1:0];
                     end
`else
                     ADData <= shreg[DATA_BITS-1:0];
`endif
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifndef ADC_LEAD_CHECK_EN
   assign ADErrFlag = 1'b0;
`endif

endmodule

// File: tb/tb_adc_read_control.sv
// Scoreboard bench for adc_read_control with a behavioural ADC driving DOUT_AD.
module tb_adc_read_control;

   typedef struct packed {
      logic [11:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic        ADStartFlag = 1'b0;
   logic        DOUT_AD = 1'b0;
   logic        SCLK_AD;
   logic        CS_AD;
   logic [11:0] ADData;
   logic        ADRdFinishFlag;
   logic        ADBusy;
   logic        ADErrFlag;

   int          errors = 0;
   int          checks = 0;
   exp_t        expQ[$];
   logic [11:0] lastData = 12'h000;
   logic [15:0] adcFrame = 16'h0000;
   bit          abortFrame = 1'b0;
   int          csFalls = 0;
   int          lowRises = 0;
   int          gapFalls = 0;
   int          busyViol = 0;

   adc_read_control dut (
      .clk            (clk),
      .Reset          (Reset),
      .ADStartFlag    (ADStartFlag),
      .DOUT_AD        (DOUT_AD),
      .SCLK_AD        (SCLK_AD),
      .CS_AD          (CS_AD),
      .ADData         (ADData),
      .ADRdFinishFlag (ADRdFinishFlag),
      .ADBusy         (ADBusy),
      .ADErrFlag      (ADErrFlag)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outcome of one completed frame, from the frame the ADC sends.
   task automatic pushExp(input logic [15:0] f);
      exp_t e;
`ifdef ADC_LEAD_CHECK_EN
      if (f[15:12] != 4'h0) e = '{data: lastData, err: 1'b1};
      else                  e = '{data: f[11:0],  err: 1'b0};
`else
      e = '{data: f[11:0], err: 1'b0};
`endif
      lastData = e.data;
      expQ.push_back(e);
   endtask

   // ADC model and monitor: DOUT_AD changes after SCLK falls; checks on finish.
   initial begin
      logic prevSclk = 1'b0;
      logic prevCs   = 1'b1;
      logic rise, fall;
      int   bitIdx = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         rise = SCLK_AD && !prevSclk;
         fall = !SCLK_AD && prevSclk;
         if (prevCs && !CS_AD) begin
            csFalls++;
            lowRises = 0;
            gapFalls = 0;
            bitIdx   = 15;
            DOUT_AD  = adcFrame[bitIdx];
         end else if (!CS_AD && fall && bitIdx > 0) begin
            bitIdx--;
            DOUT_AD = adcFrame[bitIdx];
         end
         if (!CS_AD && rise) lowRises++;
         if (CS_AD && fall) gapFalls++;
         if (!prevCs && CS_AD && !abortFrame) chk("frameSclkRises", lowRises, 16);
         if (ADRdFinishFlag) begin
            chk("gapSclkFalls", gapFalls, 11);
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpectedFinish: ADData=0x%0h, expected no finish pulse at %0t", ADData, $time);
            end else begin
               e = expQ.pop_front();
               chk("ADData", {20'h0, ADData}, {20'h0, e.data});
               chk("ADErrFlag", {31'h0, ADErrFlag}, {31'h0, e.err});
            end
         end else if (ADErrFlag) begin
            chk("strayErrFlag", {31'h0, ADErrFlag}, 32'h0);
         end
         prevSclk = SCLK_AD;
         prevCs   = CS_AD;
      end
   end

   task automatic startRead(input logic [15:0] f, input bit expectDone);
      adcFrame = f;
      if (expectDone) pushExp(f);
      ADStartFlag = 1'b1;
      @(negedge clk);
      ADStartFlag = 1'b0;
      chk("busyAfterStart", {31'h0, ADBusy}, 32'h1);
   endtask

   task automatic waitFinish();
      int n = 0;
      while (!ADRdFinishFlag && n < 300) begin
         if (!ADBusy) busyViol++;
         @(negedge clk);
         n++;
      end
      if (!ADRdFinishFlag) chk("finishTimeout", 32'h0, 32'h1);
   endtask

   task automatic waitLowRises(input int target);
      int n = 0;
      while (!(!CS_AD && lowRises >= target) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("lowRisesTimeout", 32'h0, 32'h1);
   endtask

   task automatic waitRise(output int cycles);
      logic p;
      p = SCLK_AD;
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
         if (SCLK_AD && !p) break;
         p = SCLK_AD;
      end while (cycles < 20);
   endtask

   initial begin
      int n;
      int f0;
      Reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rstSclk",   {31'h0, SCLK_AD},        32'h0);
      chk("rstCs",     {31'h0, CS_AD},          32'h1);
      chk("rstData",   {20'h0, ADData},         32'h0);
      chk("rstFinish", {31'h0, ADRdFinishFlag}, 32'h0);
      chk("rstBusy",   {31'h0, ADBusy},         32'h0);
      chk("rstErr",    {31'h0, ADErrFlag},      32'h0);
      Reset = 1'b0;

      waitRise(n);
      waitRise(n);
      chk("sclkPeriod1", n, 8);
      waitRise(n);
      chk("sclkPeriod2", n, 8);

      // Mid-frame reset while ADData still holds its reset value.
      abortFrame = 1'b1;
      startRead(16'h0555, 1'b0);
      waitLowRises(8);
      Reset = 1'b1;
      @(negedge clk);
      chk("abortCsHigh", {31'h0, CS_AD},  32'h1);
      chk("abortBusy",   {31'h0, ADBusy}, 32'h0);
      Reset = 1'b0;
      repeat (300) @(negedge clk);
      chk("abortDataKept", {20'h0, ADData}, 32'h0);
      abortFrame = 1'b0;

      startRead(16'h0ABC, 1'b1);
      waitFinish();
      @(negedge clk);

      // Second start mid-SHIFT must be dropped.
      f0 = csFalls;
      busyViol = 0;
      startRead(16'h0765, 1'b1);
      waitLowRises(4);
      ADStartFlag = 1'b1;
      @(negedge clk);
      ADStartFlag = 1'b0;
      waitFinish();
      repeat (250) @(negedge clk);
      chk("busyIgnoreFrames", csFalls - f0, 1);
      chk("busyThroughout", busyViol, 0);

      // Back-to-back: a start during the finish cycle is ignored, the next one taken.
      f0 = csFalls;
      startRead(16'h0FFF, 1'b1);
      waitFinish();
      adcFrame = 16'h0001;
      ADStartFlag = 1'b1;
      @(negedge clk);
      chk("doneStartIgnored", {31'h0, ADBusy}, 32'h0);
      pushExp(16'h0001);
      @(negedge clk);
      ADStartFlag = 1'b0;
      chk("nextStartTaken", {31'h0, ADBusy}, 32'h1);
      waitFinish();
      @(negedge clk);
      chk("backToBackFrames", csFalls - f0, 2);

      startRead(16'h8123, 1'b1);
      waitFinish();
      repeat (20) @(negedge clk);
      chk("scoreboardEmpty", expQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
